store_narrow: RTL and testbench
===============================

STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles mem_we is held awaiting mem_ack before abort (range 1..15).
REQ-002 clk  in  1  rising-edge system clock; single clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  store request present.
REQ-005 req_ready  out  1  block can accept a request this cycle.
REQ-006 req_addr  in  32  byte address of store.
REQ-007 req_data  in  32  register value (rt); only low byte/half used for sub-word sizes.
REQ-008 req_size  in  2  00 byte (sb), 01 half (sh), 10 word (sw), 11 illegal.
REQ-009 mem_we  out  1  write strobe to data memory.
REQ-010 mem_addr  out  32  word-aligned address, req_addr with bits [1:0] forced to 0.
REQ-011 mem_wdata  out  32  lane-replicated write data.
REQ-012 mem_be  out  4  byte enables, bit 3 = bits [31:24].
REQ-013 mem_ack  in  1  memory write complete, sampled only while mem_we=1.
REQ-014 misalign  out  1  one-cycle pulse: request rejected (misaligned or illegal size).
REQ-015 timeout  out  1  one-cycle pulse: write aborted, no ack within TIMEOUT cycles.

Function
REQ-016 States: IDLE, WRITE; req_ready SHALL be 1 exactly in IDLE.
REQ-017 Handshake: request accepted on a clk edge with req_valid=1 and req_ready=1; inputs not sampled otherwise.
REQ-018 Alignment: half legal iff addr[0]=0; word legal iff addr[1:0]=00; byte always legal; size 11 always illegal.
REQ-019 Illegal accept: misalign=1 the following cycle, state stays IDLE, mem_we stays 0, no memory outputs change.
REQ-020 Legal accept: next cycle state=WRITE, mem_we=1, mem_addr/mem_wdata/mem_be registered from the request (latency 1).
REQ-021 Byte order is big-endian: byte offset 0 maps to lane 3.
REQ-022 Byte: mem_wdata = req_data[7:0] replicated ×4; mem_be = 1000 shifted right by addr[1:0].
REQ-023 Half: mem_wdata = req_data[15:0] replicated ×2; mem_be = 1100 if addr[1]=0, else 0011.
REQ-024 Word: mem_wdata = req_data; mem_be = 1111.
REQ-025 Narrowing discards req_data upper bits; no sign/zero information is carried to memory.
REQ-026 WRITE: mem_we and all mem_* outputs held stable until mem_ack=1 or timeout.
REQ-027 mem_ack=1 in WRITE: next cycle IDLE, mem_we=0, mem_be=0000; a new request is acceptable the cycle after.
REQ-028 Wait counter: cleared on WRITE entry, increments each WRITE cycle with mem_ack=0; reaching TIMEOUT: next cycle IDLE, mem_we=0, timeout=1 for one cycle.
REQ-029 mem_ack on the same cycle the counter reaches TIMEOUT: ack wins, no timeout pulse.
REQ-030 mem_ack while in IDLE ignored.
REQ-031 misalign and timeout never asserted simultaneously.

Reset
REQ-032 On reset: state=IDLE, req_ready=1 after release, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0000, misalign=0, timeout=0, counter=0.
REQ-033 Reset mid-WRITE aborts the write with no timeout pulse; mem_we=0 in the first cycle after the reset edge.
REQ-034 Reset has priority over every other input.

Structure
REQ-035 Shared package holds: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state type, TIMEOUT default.
REQ-036 One combinational sub-module, store_lane_fmt (addr[1:0], size, data -> wdata, be, legal), instantiated once; FSM, counter and registers stay in store_narrow.

Verification
REQ-037 sb addr=0x1003 data=0xDEADBEEF, ack after 2 cycles -> mem_addr=0x1000, wdata=0xEFEFEFEF, be=0001, mem_we high 2 cycles, then IDLE.
REQ-038 sh addr=0x2002 data=0x12345678, immediate ack -> wdata=0x56785678, be=0011; sw addr=0x2004 -> wdata=data, be=1111.
REQ-039 sw addr=0x3001, then sh addr=0x3001, then size=11 -> misalign pulse each, mem_we never asserted, req_ready stays 1.
REQ-040 sb with mem_ack held 0 (TIMEOUT=15) -> mem_we high exactly 15 cycles, single timeout pulse, return to IDLE; repeat with ack on cycle 15 -> no timeout.
REQ-041 Reset asserted during WRITE cycle 3 -> mem_we=0 next cycle, all outputs at reset values, no timeout pulse; next request processed normally.
REQ-042 Back-to-back requests with req_valid held high -> accept, WRITE, ack, IDLE-accept; no request lost or duplicated.

Source files
------------

// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store_narrow block.
//   - Store size encodings as carried on req_size.
//   - FSM state type.
//   - Default write-acknowledge timeout.
package store_narrow_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } state_e;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational lane formatter for sub-word stores (big-endian lanes).
// Ports:
//   addr_lo - byte offset within the word (req_addr[1:0])
//   size    - store size encoding
//   data    - register value; only the low byte/half is used for sub-word sizes
//   wdata   - lane-replicated write data
//   be      - byte enables, bit 3 covers bits [31:24]
//   legal   - request is aligned and of a legal size
module store_lane_fmt
  import store_narrow_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        legal
);

  always_comb begin
    wdata = '0;
    be    = '0;
    legal = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        legal = 1'b1;
        wdata = {4{data[7:0]}};
        // Offset 0 lands in lane 3.
        be    = 4'b1000 >> addr_lo;
      end
      SZ_HALF: begin
        legal = ~addr_lo[0];
        wdata = {2{data[15:0]}};
        be    = addr_lo[1] ? 4'b0011 : 4'b1100;
      end
      SZ_WORD: begin
        legal = (addr_lo == 2'b00);
        wdata = data;
        be    = 4'b1111;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow.sv
// Store-narrowing unit: accepts one store request at a time, formats it into
// a word-aligned memory write with byte enables, holds the write until the
// memory acknowledges or a wait budget of TIMEOUT cycles runs out.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   req_valid/req_ready             - request handshake
//   req_addr/req_data/req_size      - store request
//   mem_we/mem_addr/mem_wdata/mem_be - memory write port, mem_ack completes it
//   misalign                        - one-cycle pulse on a rejected request
//   timeout                         - one-cycle pulse on an aborted write
module store_narrow
  import store_narrow_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        misalign,
  output logic        timeout
);

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic        fmt_legal;

  store_lane_fmt u_fmt (
    .addr_lo (req_addr[1:0]),
    .size    (req_size),
    .data    (req_data),
    .wdata   (fmt_wdata),
    .be      (fmt_be),
    .legal   (fmt_legal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (fmt_legal) begin
            state_d = StWrite;
            cnt_d   = '0;
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = fmt_wdata;
            be_d    = fmt_be;
          end else begin
            // Rejected: memory-side registers are left untouched.
            misalign_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (mem_ack) begin
          // Ack wins even on the cycle the budget would run out.
          state_d = StIdle;
          be_d    = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TimeoutCnt) begin
            state_d   = StIdle;
            be_d      = '0;
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_we    = (state_q == StWrite);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign misalign  = misalign_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow.
module tb_store_narrow;
  import store_narrow_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        misalign;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  store_narrow #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .misalign  (misalign),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_size  = size;
    req_addr  = addr;
    req_data  = data;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, " we"}, mem_we, 0);
    chk({tag, " be"}, mem_be, 0);
    chk({tag, " ready"}, req_ready, 1);
    chk({tag, " timeout"}, timeout, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = SZ_BYTE;
    mem_ack   = 1'b0;
    tick();
    tick();
    chk("rst ready", req_ready, 1);
    chk("rst we", mem_we, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst be", mem_be, 0);
    chk("rst misalign", misalign, 0);
    chk("rst timeout", timeout, 0);
    reset = 1'b0;
    tick();

    // sb 0x1003, ack on second WRITE cycle
    issue(SZ_BYTE, 32'h0000_1003, 32'hDEAD_BEEF);
    chk("sb we c1", mem_we, 1);
    chk("sb addr", mem_addr, 32'h0000_1000);
    chk("sb wdata", mem_wdata, 32'hEFEF_EFEF);
    chk("sb be", mem_be, 4'b0001);
    chk("sb ready", req_ready, 0);
    tick();
    chk("sb we c2", mem_we, 1);
    chk("sb addr c2", mem_addr, 32'h0000_1000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outs("sb done");

    // sh 0x2002 immediate ack
    issue(SZ_HALF, 32'h0000_2002, 32'h1234_5678);
    chk("sh we", mem_we, 1);
    chk("sh addr", mem_addr, 32'h0000_2000);
    chk("sh wdata", mem_wdata, 32'h5678_5678);
    chk("sh be", mem_be, 4'b0011);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outs("sh done");

    // sw 0x2004
    issue(SZ_WORD, 32'h0000_2004, 32'h1234_5678);
    chk("sw addr", mem_addr, 32'h0000_2004);
    chk("sw wdata", mem_wdata, 32'h1234_5678);
    chk("sw be", mem_be, 4'b1111);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outs("sw done");

    // Rejections: misaligned word, misaligned half, illegal size
    issue(SZ_WORD, 32'h0000_3001, 32'h1111_1111);
    chk("mis sw pulse", misalign, 1);
    chk("mis sw we", mem_we, 0);
    chk("mis sw ready", req_ready, 1);
    chk("mis sw addr held", mem_addr, 32'h0000_2004);
    chk("mis sw wdata held", mem_wdata, 32'h1234_5678);
    issue(SZ_HALF, 32'h0000_3001, 32'h2222_2222);
    chk("mis sh pulse", misalign, 1);
    chk("mis sh we", mem_we, 0);
    chk("mis sh timeout", timeout, 0);
    issue(SZ_ILL, 32'h0000_3000, 32'h3333_3333);
    chk("mis ill pulse", misalign, 1);
    chk("mis ill we", mem_we, 0);
    chk("mis ill ready", req_ready, 1);
    tick();
    chk("mis pulse end", misalign, 0);

    // Timeout: no ack at all
    issue(SZ_BYTE, 32'h0000_4000, 32'h0000_00A5);
    chk("to wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("to be", mem_be, 4'b1000);
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("to we c%0d", k), mem_we, 1);
      chk($sformatf("to pulse c%0d", k), timeout, 0);
      tick();
    end
    chk("to we off", mem_we, 0);
    chk("to pulse", timeout, 1);
    chk("to misalign", misalign, 0);
    tick();
    chk("to pulse end", timeout, 0);
    chk("to ready", req_ready, 1);

    // Ack on cycle 15 beats the timeout
    issue(SZ_BYTE, 32'h0000_4002, 32'h0000_005A);
    for (int k = 1; k <= 14; k++) tick();
    chk("ack15 we", mem_we, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outs("ack15 done");

    // Reset during WRITE cycle 3
    issue(SZ_WORD, 32'h0000_5000, 32'h0BAD_F00D);
    tick();
    tick();
    chk("rstw we c3", mem_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw we", mem_we, 0);
    chk("rstw addr", mem_addr, 0);
    chk("rstw wdata", mem_wdata, 0);
    chk("rstw be", mem_be, 0);
    chk("rstw timeout", timeout, 0);
    chk("rstw ready", req_ready, 1);
    tick();
    chk("rstw timeout later", timeout, 0);
    issue(SZ_BYTE, 32'h0000_5001, 32'h0000_0077);
    chk("post rst wdata", mem_wdata, 32'h7777_7777);
    chk("post rst be", mem_be, 4'b0100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outs("post rst done");

    // Back-to-back with req_valid held high
    req_valid = 1'b1;
    req_size  = SZ_HALF;
    req_addr  = 32'h0000_6000;
    req_data  = 32'hAAAA_BBBB;
    tick();
    chk("b2b first we", mem_we, 1);
    chk("b2b first wdata", mem_wdata, 32'hBBBB_BBBB);
    chk("b2b first be", mem_be, 4'b1100);
    // Second request presented while busy: must not be sampled yet
    req_size = SZ_WORD;
    req_addr = 32'h0000_6008;
    req_data = 32'hCAFE_F00D;
    mem_ack  = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b idle we", mem_we, 0);
    chk("b2b idle ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b second we", mem_we, 1);
    chk("b2b second addr", mem_addr, 32'h0000_6008);
    chk("b2b second wdata", mem_wdata, 32'hCAFE_F00D);
    chk("b2b second be", mem_be, 4'b1111);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outs("b2b done");
    tick();
    chk("b2b no dup", mem_we, 0);

    // Ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    idle_outs("idle ack");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
